// File: rtl/riscv_bram_mem_ctrl_if.sv
// Bus between the RISC-V core memory port and riscv_bram_mem_ctrl:
// command channel, write-data channel and read-response channel.
interface riscv_bram_mem_ctrl_if #(
    parameter int DATA_BITS = 128,
    parameter int ADDR_BITS = 26,
    parameter int TAG_BITS  = 4
);
    // mem_req and mem_wdata transfer on every cycle where val and rdy are both
    // high at the rising clock edge; val must not wait for rdy. mem_resp has no
    // ready: each cycle with mem_resp_val high delivers exactly one read beat.
    logic                 mem_req_val;
    logic                 mem_req_rdy;
    logic                 mem_req_rw;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic [TAG_BITS-1:0]  mem_req_tag;
    logic                 mem_wdata_val;
    logic                 mem_wdata_rdy;
    logic [DATA_BITS-1:0] mem_wdata_bits;
    logic                 mem_resp_val;
    logic [DATA_BITS-1:0] mem_resp_data;
    logic [TAG_BITS-1:0]  mem_resp_tag;
    logic                 mem_resp_err;

    modport master (
        output mem_req_val, mem_req_rw, mem_req_addr, mem_req_tag,
        output mem_wdata_val, mem_wdata_bits,
        input  mem_req_rdy, mem_wdata_rdy,
        input  mem_resp_val, mem_resp_data, mem_resp_tag, mem_resp_err
    );

    modport slave (
        input  mem_req_val, mem_req_rw, mem_req_addr, mem_req_tag,
        input  mem_wdata_val, mem_wdata_bits,
        output mem_req_rdy, mem_wdata_rdy,
        output mem_resp_val, mem_resp_data, mem_resp_tag, mem_resp_err
    );
endinterface

// File: rtl/riscv_bram_mem_ctrl.sv
// Block-RAM main memory with a command queue and multi-beat line transfers.
// Define MEM_ADDR_CHECK_EN to flag accesses that hit no mapped region.
module riscv_bram_mem_ctrl #(
    parameter int DATA_BITS        = 128,
    parameter int BEATS            = 4,
    parameter int ADDR_BITS        = 26,
    parameter int TAG_BITS         = 4,
    parameter int REQ_DEPTH        = 4,
    parameter int NREGIONS         = 4,
    parameter int REGION_LINE_BITS = 12,
    parameter logic [NREGIONS*ADDR_BITS-1:0] REGION_BASE =
        {26'h3800000, 26'h2000000, 26'h1000, 26'h0}
) (
    input  logic                 clk,
    input  logic                 reset,
    riscv_bram_mem_ctrl_if.slave bus,
    output logic [1:0]           dbg_state
);
    localparam int BB       = $clog2(BEATS);
    localparam int RB       = (NREGIONS > 1) ? $clog2(NREGIONS) : 1;
    localparam int IDX_BITS = RB + REGION_LINE_BITS + BB;
    localparam int PB       = $clog2(REQ_DEPTH);
    localparam int CB       = PB + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [BB-1:0]         beat_q, beat_d;
    logic [ADDR_BITS-1:0]  cur_addr_q, cur_addr_d;
    logic [TAG_BITS-1:0]   cur_tag_q, cur_tag_d;
    logic [PB-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CB-1:0]         count_q, count_d;
    logic                  resp_val_q, resp_val_d;
    logic [DATA_BITS-1:0]  rdata_q;

    logic                  q_rw   [REQ_DEPTH];
    logic [ADDR_BITS-1:0]  q_addr [REQ_DEPTH];
    logic [TAG_BITS-1:0]   q_tag  [REQ_DEPTH];
    logic [DATA_BITS-1:0]  ram    [2**IDX_BITS];

    logic                  push, pop;
    logic                  hit_any, mapped;
    logic [RB-1:0]         hit_idx, region;
    logic [ADDR_BITS-1:0]  reg_base, reg_off;
    logic [IDX_BITS-1:0]   ram_idx;
    logic                  ram_we, ram_re;

    assign bus.mem_req_rdy   = count_q < CB'(REQ_DEPTH);
    assign bus.mem_wdata_rdy = state_q == S_WRITE;
    assign push              = bus.mem_req_val & bus.mem_req_rdy;
    assign pop               = (state_q == S_IDLE) && (count_q != '0);
    assign dbg_state         = state_q;

    // Walk regions from high to low so the lowest-indexed hit wins.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        reg_base = '0;
        reg_off  = '0;
        for (int r = NREGIONS - 1; r >= 0; r--) begin
            reg_base = REGION_BASE[r*ADDR_BITS +: ADDR_BITS];
            reg_off  = cur_addr_q - reg_base;
            if ((cur_addr_q >= reg_base) && ((reg_off >> REGION_LINE_BITS) == '0)) begin
                hit_any = 1'b1;
                hit_idx = RB'(r);
            end
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    logic resp_err_q, resp_err_d;

    assign mapped            = hit_any;
    assign region            = hit_idx;
    assign resp_err_d        = (state_q == S_READ) && !mapped;
    assign bus.mem_resp_err  = resp_err_q;
    assign bus.mem_resp_data = resp_err_q ? '0 : rdata_q;

    always_ff @(posedge clk) begin
        if (reset) resp_err_q <= 1'b0;
        else       resp_err_q <= resp_err_d;
    end
`else
    // Unmapped lines fold into the last window using their low address bits.
    assign mapped            = 1'b1;
    assign region            = hit_any ? hit_idx : RB'(NREGIONS - 1);
    assign bus.mem_resp_err  = 1'b0;
    assign bus.mem_resp_data = rdata_q;
`endif

    assign ram_idx          = {region, cur_addr_q[REGION_LINE_BITS-1:0], beat_q};
    assign ram_re           = state_q == S_READ;
    assign ram_we           = (state_q == S_WRITE) && bus.mem_wdata_val && mapped && !reset;
    assign bus.mem_resp_val = resp_val_q;
    assign bus.mem_resp_tag = cur_tag_q;

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_idx] <= bus.mem_wdata_bits;
        if (ram_re) rdata_q <= ram[ram_idx];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rw[wr_ptr_q]   <= bus.mem_req_rw;
            q_addr[wr_ptr_q] <= bus.mem_req_addr;
            q_tag[wr_ptr_q]  <= bus.mem_req_tag;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        cur_addr_d = cur_addr_q;
        cur_tag_d  = cur_tag_q;
        resp_val_d = 1'b0;
        wr_ptr_d   = push ? wr_ptr_q + PB'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PB'(1) : rd_ptr_q;
        count_d    = count_q + CB'(push) - CB'(pop);
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    cur_addr_d = q_addr[rd_ptr_q];
                    cur_tag_d  = q_tag[rd_ptr_q];
                    beat_d     = '0;
                    state_d    = q_rw[rd_ptr_q] ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                resp_val_d = 1'b1;
                beat_d     = beat_q + BB'(1);
                if (beat_q == BB'(BEATS - 1)) state_d = S_IDLE;
            end
            S_WRITE: begin
                if (bus.mem_wdata_val) begin
                    beat_d = beat_q + BB'(1);
                    if (beat_q == BB'(BEATS - 1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            resp_val_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            resp_val_q <= resp_val_d;
        end
    end

    // Current command fields need no reset: they are loaded on every pop.
    always_ff @(posedge clk) begin
        cur_addr_q <= cur_addr_d;
        cur_tag_q  <= cur_tag_d;
    end
endmodule

// File: tb/tb_riscv_bram_mem_ctrl.sv
// Self-checking bench for riscv_bram_mem_ctrl: directed scenarios plus random
// traffic, checked against a line-level memory model and an expected-beat queue.
module tb_riscv_bram_mem_ctrl;
    localparam int DATA_BITS = 128;
    localparam int BEATS     = 4;
    localparam int ADDR_BITS = 26;
    localparam int TAG_BITS  = 4;
    localparam int NREGIONS  = 4;
    localparam int LINES     = 4096;
    localparam int CW        = DATA_BITS + TAG_BITS + 1;
`ifdef MEM_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_bram_mem_ctrl_if #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS), .TAG_BITS(TAG_BITS)) bus ();

    riscv_bram_mem_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [DATA_BITS-1:0] ref_mem [int];
    logic [CW-1:0]        exp_q[$];
    logic [DATA_BITS-1:0] wbeat_q[$];
    logic [DATA_BITS-1:0] next_wdata [BEATS];
    int                   beat_cyc_q[$];
    int                   n_cmp = 0;
    int                   n_bad = 0;
    int                   wbeats_taken = 0;
    bit                   wfeed_en = 1'b1;
    int                   stall_mode = 0;

    task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int region_base(input int r);
        case (r)
            0:       return 'h0;
            1:       return 'h1000;
            2:       return 'h2000000;
            default: return 'h3800000;
        endcase
    endfunction

    // Physical line slot of an address; unmapped lines fold into the last window.
    function automatic int line_slot(input logic [ADDR_BITS-1:0] a, output bit mapped);
        int ai;
        int slot;
        ai     = int'(a);
        mapped = 1'b0;
        slot   = (NREGIONS - 1) * LINES + (ai % LINES);
        for (int r = 0; r < NREGIONS; r++) begin
            if (!mapped && ai >= region_base(r) && ai < region_base(r) + LINES) begin
                mapped = 1'b1;
                slot   = r * LINES + (ai - region_base(r));
            end
        end
        return slot;
    endfunction

    task automatic fill_rand();
        for (int b = 0; b < BEATS; b++)
            next_wdata[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // ---------------- driver ----------------
    task automatic send_cmd(input bit rw, input logic [ADDR_BITS-1:0] addr,
                            input logic [TAG_BITS-1:0] tag, output int push_cyc);
        bit mapped;
        int slot;
        int w;
        slot = line_slot(addr, mapped);
        w = 0;
        while (!bus.mem_req_rdy && w < 200) begin
            @(negedge clk);
            w++;
        end
        push_cyc = cyc;
        if (!bus.mem_req_rdy) begin
            chk("req_rdy_timeout", CW'(0), CW'(1));
            return;
        end
        bus.mem_req_val  = 1'b1;
        bus.mem_req_rw   = rw;
        bus.mem_req_addr = addr;
        bus.mem_req_tag  = tag;
        for (int b = 0; b < BEATS; b++) begin
            if (rw) begin
                wbeat_q.push_back(next_wdata[b]);
                if (!(ADDR_CHECK && !mapped)) ref_mem[slot*BEATS + b] = next_wdata[b];
            end else if (ADDR_CHECK && !mapped) begin
                exp_q.push_back({1'b1, tag, {DATA_BITS{1'b0}}});
            end else begin
                exp_q.push_back({1'b0, tag, ref_mem[slot*BEATS + b]});
            end
        end
        @(negedge clk);
        bus.mem_req_val = 1'b0;
        push_cyc = cyc;
    endtask

    // Write-data feeder: offers the next queued beat; a beat offered while rdy
    // is high is taken at the following rising edge.
    initial begin
        bit tgl;
        bit go;
        tgl = 1'b0;
        bus.mem_wdata_val  = 1'b0;
        bus.mem_wdata_bits = '0;
        forever begin
            @(negedge clk);
            go = wfeed_en && (wbeat_q.size() > 0);
            if (stall_mode == 1) go = go && tgl;
            if (stall_mode == 2) go = go && ($urandom_range(0, 1) == 1);
            tgl = !tgl;
            bus.mem_wdata_val  = go;
            bus.mem_wdata_bits = go ? wbeat_q[0] : '0;
            if (go && bus.mem_wdata_rdy) begin
                void'(wbeat_q.pop_front());
                wbeats_taken++;
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        logic [CW-1:0] e;
        if (bus.mem_resp_val === 1'b1) begin
            beat_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", CW'(1), CW'(0));
            end else begin
                e = exp_q.pop_front();
                chk("resp_beat", {bus.mem_resp_err, bus.mem_resp_tag, bus.mem_resp_data}, e);
            end
        end
    end

    task automatic drain();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && wbeat_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0 || wbeat_q.size() != 0) begin
            chk("drain_timeout", CW'(exp_q.size() + wbeat_q.size()), CW'(0));
            exp_q.delete();
            wbeat_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within budget");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int pc;
        int cnt;
        int base_taken;
        bit seen;
        bit rw;
        bit mp;
        int slot;
        logic [ADDR_BITS-1:0] a;

        reset = 1'b1;
        bus.mem_req_val  = 1'b0;
        bus.mem_req_rw   = 1'b0;
        bus.mem_req_addr = '0;
        bus.mem_req_tag  = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_rdy",   CW'(bus.mem_req_rdy),   CW'(1));
        chk("rst_wdata_rdy", CW'(bus.mem_wdata_rdy), CW'(0));
        chk("rst_resp_val",  CW'(bus.mem_resp_val),  CW'(0));
        chk("rst_resp_err",  CW'(bus.mem_resp_err),  CW'(0));
        reset = 1'b0;

        // Basic line write then read with latency check
        next_wdata[0] = {16{8'h11}};
        next_wdata[1] = {16{8'h22}};
        next_wdata[2] = {16{8'h33}};
        next_wdata[3] = {16{8'h44}};
        send_cmd(1'b1, 26'h1000, 4'd0, pc);
        drain();
        beat_cyc_q.delete();
        send_cmd(1'b0, 26'h1000, 4'd3, pc);
        drain();
        chk("rd_beat_count", CW'(beat_cyc_q.size()), CW'(BEATS));
        for (int k = 0; k < BEATS && k < beat_cyc_q.size(); k++)
            chk("rd_latency", CW'(beat_cyc_q[k]), CW'(pc + 2 + k));

        // Windows at 0x0 and 0x2000000 must not alias
        fill_rand();
        send_cmd(1'b1, 26'h0, 4'd0, pc);
        fill_rand();
        send_cmd(1'b1, 26'h2000000, 4'd0, pc);
        send_cmd(1'b0, 26'h0, 4'd1, pc);
        send_cmd(1'b0, 26'h2000000, 4'd2, pc);
        drain();

        // Fill the queue behind a stalled write
        wfeed_en = 1'b0;
        fill_rand();
        send_cmd(1'b1, 26'h1001, 4'd0, pc);
        cnt = 0;
        while (!bus.mem_wdata_rdy && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("fill_in_write", CW'(bus.mem_wdata_rdy), CW'(1));
        beat_cyc_q.delete();
        send_cmd(1'b0, 26'h1000,    4'd4, pc);
        send_cmd(1'b0, 26'h0,       4'd5, pc);
        send_cmd(1'b0, 26'h2000000, 4'd6, pc);
        send_cmd(1'b0, 26'h1001,    4'd7, pc);
        chk("fill_full_rdy", CW'(bus.mem_req_rdy), CW'(0));
        repeat (3) @(negedge clk);
        chk("fill_full_hold", CW'(bus.mem_req_rdy), CW'(0));
        wfeed_en = 1'b1;
        cnt = 0;
        while (bus.mem_wdata_rdy && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("fill_no_bypass", CW'({bus.mem_wdata_rdy, bus.mem_req_rdy}), CW'(0));
        @(negedge clk);
        chk("fill_rdy_after_pop", CW'(bus.mem_req_rdy), CW'(1));
        drain();
        chk("fill_beat_count", CW'(beat_cyc_q.size()), CW'(4 * BEATS));
        for (int k = 1; k < beat_cyc_q.size(); k++)
            chk("fill_spacing", CW'(beat_cyc_q[k] - beat_cyc_q[0]),
                CW'((k / BEATS) * (BEATS + 1) + (k % BEATS)));

        // Write with toggling write-data valid
        stall_mode = 1;
        fill_rand();
        base_taken = wbeats_taken;
        send_cmd(1'b1, 26'h2000005, 4'd0, pc);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.mem_wdata_rdy) seen = 1'b1;
            else if (seen) break;
            @(negedge clk);
        end
        chk("stall_beats_at_idle", CW'(wbeats_taken - base_taken), CW'(BEATS));
        stall_mode = 0;
        send_cmd(1'b0, 26'h2000005, 4'd9, pc);
        drain();

        // Reset in the middle of a read
        send_cmd(1'b0, 26'h1000, 4'd10, pc);
        cnt = 0;
        for (int i = 0; i < 40 && cnt < 2; i++) begin
            @(negedge clk);
            if (bus.mem_resp_val) cnt++;
        end
        chk("mid_rst_two_beats", CW'(cnt), CW'(2));
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_resp_val", CW'(bus.mem_resp_val),  CW'(0));
        chk("mid_rst_req_rdy",  CW'(bus.mem_req_rdy),   CW'(1));
        chk("mid_rst_wdata",    CW'(bus.mem_wdata_rdy), CW'(0));
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_dropped", CW'(exp_q.size()), CW'(BEATS - 2));
        exp_q.delete();
        repeat (5) @(negedge clk);
        send_cmd(1'b0, 26'h1000, 4'd11, pc);
        drain();

        // Unmapped line 0x3000000: error beats with the check, alias otherwise
        fill_rand();
        send_cmd(1'b1, 26'h3800000, 4'd0, pc);
        send_cmd(1'b0, 26'h3000000, 4'd12, pc);
        fill_rand();
        send_cmd(1'b1, 26'h3000000, 4'd0, pc);
        send_cmd(1'b0, 26'h3800000, 4'd13, pc);
        drain();

        // Random traffic with random write-data stalls
        stall_mode = 2;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0, 1, 2, 3: a = ADDR_BITS'(region_base($urandom_range(0, 3)) +
                               ($urandom_range(0, 1) ? $urandom_range(0, 3) : LINES - 4 + $urandom_range(0, 3)));
                default:    a = ADDR_BITS'('h100000 + $urandom_range(0, 3));
            endcase
            rw = ($urandom_range(0, 2) == 0);
            slot = line_slot(a, mp);
            if (!rw && !(ADDR_CHECK && !mp) && !ref_mem.exists(slot * BEATS)) rw = 1'b1;
            if (rw) fill_rand();
            send_cmd(rw, a, TAG_BITS'($urandom_range(0, 15)), pc);
        end
        drain();
        stall_mode = 0;
        chk("final_idle_rdy", CW'(bus.mem_req_rdy), CW'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/riscv_bram_mem_ctrl.md
# riscv_bram_mem_ctrl

Parametrised BRAM-backed main-memory model for FPGA builds of the RISC-V core. It sits on the core's `mem_req`/`mem_resp` port and replaces the fixed single-request BRAM memory with the following:
- A command queue, so requests are accepted while a transfer is in flight.
- A separate write-data channel.
- Parametrised line width, beat count, tag width and region map.

Multi-beat line transfers are served from a single block RAM made of `NREGIONS` windows.

## Interface
- `DATA_BITS`, 128: beat width in bits.
- `BEATS`, 4: beats per line; power of two, ≥2.
- `ADDR_BITS`, 26: line-address width.
- `TAG_BITS`, 4: request tag width.
- `REQ_DEPTH`, 4: command queue entries; power of two, ≥2.
- `NREGIONS`, 4: mapped windows; power of two.
- `REGION_LINE_BITS`, 12: log2 of lines per window.
- `REGION_BASE`, {26'h3800000, 26'h2000000, 26'h1000, 26'h0}: packed window base line addresses, NREGIONS×ADDR_BITS; entry r occupies bits [r*ADDR_BITS +: ADDR_BITS].
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `mem_req_val` in 1: command valid.
- `mem_req_rdy` out 1: command queue not full.
- `mem_req_rw` in 1: 1 = write, 0 = read.
- `mem_req_addr` in ADDR_BITS: line address.
- `mem_req_tag` in TAG_BITS: tag returned with read data.
- `mem_wdata_val` in 1: write beat valid.
- `mem_wdata_rdy` out 1: write beat accepted.
- `mem_wdata_bits` in DATA_BITS: write beat data.
- `mem_resp_val` out 1: read beat valid; no backpressure.
- `mem_resp_data` out DATA_BITS: read beat data.
- `mem_resp_tag` out TAG_BITS: tag of the current read.
- `mem_resp_err` out 1: unmapped access (see Configuration).

## Operation
- **RAM.** The RAM holds NREGIONS·2^REGION_LINE_BITS·BEATS words of DATA_BITS bits.
  - Word index = {region, addr[REGION_LINE_BITS-1:0], beat}.
  - Region r hits when REGION_BASE[r] ≤ addr < REGION_BASE[r] + 2^REGION_LINE_BITS.
  - If several regions hit, the lowest index wins.
- **Command queue.** FIFO of {rw, addr, tag}, REQ_DEPTH entries.
  - Push on `mem_req_val & mem_req_rdy`.
  - `mem_req_rdy` = count < REQ_DEPTH. There is no full-and-pop bypass: when the queue is full, rdy stays 0 in the cycle the head pops.
- **FSM states: IDLE, READ, WRITE.**
  - IDLE, queue non-empty: pop the head into registers, reset the beat counter to 0, go to READ or WRITE according to rw.
  - READ: issue one RAM read per cycle for beats 0..BEATS-1. After the last beat, go to IDLE.
  - WRITE: `mem_wdata_rdy` = 1. On each `mem_wdata_val` the beat is written and the counter increments. Cycles without `mem_wdata_val` are stalls. After the beat with counter = BEATS-1 is written, go to IDLE.
- **Write-data channel.** `mem_wdata_rdy` is 0 outside WRITE. Write data that arrives early is held by the sender.
- **Read responses.** `mem_resp_val` is asserted the cycle after each READ issue, with RAM output data. `mem_resp_tag` is held for all BEATS beats.
- **Reset.** The state goes to IDLE, the queue is flushed, and the counters clear. RAM contents are preserved. RAM writes are suppressed while `reset` is high.

## Timing
- **Reset values:** `mem_req_rdy` 1, `mem_wdata_rdy` 0, `mem_resp_val` 0, `mem_resp_err` 0, `mem_resp_data` and `mem_resp_tag` don't-care.
- **Read latency:** command accepted at cycle 0 into an empty queue in IDLE; pop at cycle 1; beat 0 read at cycle 2; `mem_resp_val` on cycles 3..2+BEATS.
- **Transfer spacing:** one IDLE bubble cycle between consecutive transfers.
- **Write beats:** with continuous valid, the first beat is written at cycle 2 and the last at cycle 1+BEATS.
- **Mid-read reset:** `mem_resp_val` is 0 in the cycle after `reset` is sampled high. No further beats of that read are returned.
- **Concurrent push and pop:** allowed, and the count is unchanged.
- **Pointer wrap:** modulo REQ_DEPTH.

## Configuration
- **`MEM_ADDR_CHECK_EN` defined:** an address hitting no region is flagged.
  - Read: returns BEATS beats of all-zero data with `mem_resp_err` = 1 on each beat.
  - Write: consumes all BEATS beats and discards them; the RAM is unchanged.
- **Not defined:** an unmapped address uses region NREGIONS-1, with offset bits taken from addr. `mem_resp_err` is tied to 0.

## Test plan
- Write line 0x1000 with beats 0x11..,0x22..,0x33..,0x44..; then read 0x1000 with tag 3. Required: `mem_resp_val` on 4 consecutive cycles, data in write order, tag 3 on every beat.
- Aliasing: write line 0x0 with pattern A and line 0x2000000 with pattern B, then read both back. Required: A and B each return intact, with no aliasing between windows.
- Queue fill: push 4 reads to a full queue while holding `mem_wdata` idle. Required: `mem_req_rdy` drops after the 4th push. All 16 beats return with tags in push order, with one bubble cycle between lines.
- Write stall: a write command with `mem_wdata_val` toggled 1,0,1,0,... Required: exactly 4 beats are written, no beat is duplicated, and FSM returns to IDLE only after the 4th beat.
- Reset mid-read: assert `reset` after beat 1 of a read. Required: no further `mem_resp_val`, `mem_req_rdy` = 1, and the line reads back intact after reset.
- With `MEM_ADDR_CHECK_EN`: read 0x3000000. Required: 4 beats of zero data with `mem_resp_err` = 1. A write to 0x3000000 consumes 4 beats and leaves region 3 unchanged.
